// File: rtl/mult_req_arbiter.sv
// rtl/mult_req_arbiter.sv - round-robin front-end sharing one asynchronous Booth multiplier pipeline
// between two clocked 4-phase requesters, with ack synchroniser and handshake watchdog.
module mult_req_arbiter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack1,
    output logic                 pipe_req,
    output logic [WIDTH-1:0]     pipe_a,
    output logic [WIDTH-1:0]     pipe_b,
    input  logic                 pipe_ack,
    input  logic [2*WIDTH-1:0]   pipe_prod,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 prod_owner,
    output logic                 timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ_UP,
        REQ_DOWN,
        CLIENT_ACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [CW-1:0]          wd_cnt;
    logic                   wd_expired;
    logic                   last_grant;
    logic                   any_req;
    logic                   winner;
    logic                   owner_req;

    assign ack_s      = ack_sync[SYNC_STAGES-1];
    assign wd_expired = (wd_cnt == CW'(TIMEOUT));
    assign any_req    = req0 | req1;
    // On a tie the client that did not win last time gets the pipeline.
    assign winner     = (req0 && req1) ? ~last_grant : req1;
    assign owner_req  = prod_owner ? req1 : req0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], pipe_ack};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pipe_req    <= 1'b0;
            pipe_a      <= '0;
            pipe_b      <= '0;
            prod        <= '0;
            prod_owner  <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            timeout_err <= 1'b0;
            last_grant  <= 1'b1;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        pipe_a     <= winner ? a1 : a0;
                        pipe_b     <= winner ? b1 : b0;
                        prod_owner <= winner;
                        last_grant <= winner;
                        pipe_req   <= 1'b1;
                        wd_cnt     <= '0;
                        state      <= REQ_UP;
                    end
                end
                REQ_UP: begin
                    if (ack_s) begin
                        prod     <= pipe_prod;
                        pipe_req <= 1'b0;
                        wd_cnt   <= '0;
                        state    <= REQ_DOWN;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        prod        <= '0;
                        pipe_req    <= 1'b0;
                        wd_cnt      <= '0;
                        state       <= REQ_DOWN;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                REQ_DOWN: begin
                    // A stuck-high ack still releases the client, keeping the captured product.
                    if (!ack_s || wd_expired) begin
                        if (ack_s) begin
                            timeout_err <= 1'b1;
                        end
                        if (prod_owner) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                        state <= CLIENT_ACK;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                CLIENT_ACK: begin
                    if (!owner_req) begin
                        ack0  <= 1'b0;
                        ack1  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_req_arbiter.sv
// tb/tb_mult_req_arbiter.sv - self-checking bench for mult_req_arbiter with a delayed-ack
// pipeline model and product/arbitration reference checks.
module tb_mult_req_arbiter;

    localparam int W       = 8;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          ack0, ack1;
    logic          pipe_req;
    logic [W-1:0]  pipe_a, pipe_b;
    logic          pipe_ack = 1'b0;
    logic [2*W-1:0] pipe_prod = '0;
    logic [2*W-1:0] prod;
    logic          prod_owner;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    int  dly   = 5;
    bit  stall = 1'b0;
    int  pcnt  = 0;
    int  stab_err = 0;
    bit  order_q[$];

    mult_req_arbiter #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
        .pipe_req(pipe_req), .pipe_a(pipe_a), .pipe_b(pipe_b),
        .pipe_ack(pipe_ack), .pipe_prod(pipe_prod),
        .prod(prod), .prod_owner(prod_owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Asynchronous pipeline: ack follows req after dly ns, product valid when ack rises.
    initial forever begin
        #1;
        if (pipe_req !== pipe_ack && !(stall && pipe_req === 1'b1)) begin
            pcnt++;
            if (pcnt >= dly) begin
                if (pipe_req === 1'b1) pipe_prod = 16'(pipe_a) * 16'(pipe_b);
                pipe_ack = pipe_req;
                pcnt = 0;
            end
        end else begin
            pcnt = 0;
        end
    end

    // Bundled operands must not move from grant until the transaction fully closes.
    initial begin : stab_mon
        bit busy, busy_prev;
        logic [W-1:0] pa_prev, pb_prev;
        busy_prev = 1'b0;
        pa_prev = '0;
        pb_prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                busy_prev = 1'b0;
            end else begin
                busy = pipe_req || pipe_ack || ack0 || ack1;
                if (busy && busy_prev && (pipe_a !== pa_prev || pipe_b !== pb_prev)) stab_err++;
                busy_prev = busy;
                pa_prev = pipe_a;
                pb_prev = pipe_b;
            end
        end
    end

    initial forever begin @(posedge ack0); order_q.push_back(1'b0); end
    initial forever begin @(posedge ack1); order_q.push_back(1'b1); end

    function automatic logic get_ack(input bit id);
        return id ? ack1 : ack0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic client_txn(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] expv;
        int n;
        expv = 16'(a) * 16'(b);
        @(negedge clk);
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        n = 0;
        while (get_ack(id) !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        total++;
        if (get_ack(id) !== 1'b1) begin
            bad++;
            $display("FAIL ack_rise client=%0d got=%b want=1", id, get_ack(id));
        end else begin
            total++;
            if (prod !== expv) begin
                bad++;
                $display("FAIL prod client=%0d a=%0d b=%0d got=%0d want=%0d", id, a, b, prod, expv);
            end
            total++;
            if (prod_owner !== id) begin
                bad++;
                $display("FAIL owner client=%0d got=%b want=%b", id, prod_owner, id);
            end
        end
        if (id) req1 = 1'b0; else req0 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (get_ack(id) !== 1'b0 && n < 300);
        total++;
        if (get_ack(id) !== 1'b0) begin
            bad++;
            $display("FAIL ack_fall client=%0d got=%b want=0", id, get_ack(id));
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({ack0, ack1, pipe_req, prod_owner, timeout_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000", {ack0, ack1, pipe_req, prod_owner, timeout_err});
        end
        total++;
        if ({pipe_a, pipe_b, prod} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {pipe_a, pipe_b, prod});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        dly = 5;
        a0 = 8'd3; b0 = 8'd5; req0 = 1'b1;
        @(negedge clk);
        total++;
        if (pipe_req !== 1'b1) begin bad++; $display("FAIL single_req_lat got=%b want=1", pipe_req); end
        n = 0;
        while (ack0 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        total++;
        if ({ack0, prod, prod_owner, timeout_err} !== {1'b1, 16'd15, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL single_result ack0=%b prod=%0d owner=%b terr=%b want 1/15/0/0", ack0, prod, prod_owner, timeout_err);
        end
        req0 = 1'b0;
        @(negedge clk);
        total++;
        if (ack0 !== 1'b0) begin bad++; $display("FAIL single_ack_drop got=%b want=0", ack0); end
    endtask

    task automatic test_simultaneous();
        int n;
        bit ack1_seen;
        do_reset();
        a0 = 8'd7; b0 = 8'd9; a1 = 8'd255; b1 = 8'd255;
        req0 = 1'b1; req1 = 1'b1;
        n = 0;
        ack1_seen = 1'b0;
        while (ack0 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (ack1 !== 1'b0) ack1_seen = 1'b1;
        end
        total++;
        if (ack1_seen) begin bad++; $display("FAIL sim_ack1_quiet got=1 want=0"); end
        total++;
        if ({ack0, prod, prod_owner} !== {1'b1, 16'd63, 1'b0}) begin
            bad++;
            $display("FAIL sim_first ack0=%b prod=%0d owner=%b want 1/63/0", ack0, prod, prod_owner);
        end
        req0 = 1'b0;
        n = 0;
        while (ack1 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        total++;
        if ({ack1, prod, prod_owner} !== {1'b1, 16'd65025, 1'b1}) begin
            bad++;
            $display("FAIL sim_second ack1=%b prod=%0d owner=%b want 1/65025/1", ack1, prod, prod_owner);
        end
        req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        do_reset();
        order_q.delete();
        stab_err = 0;
        fork
            begin repeat (2) client_txn(1'b0, W'($urandom), W'($urandom)); end
            begin repeat (2) client_txn(1'b1, W'($urandom), W'($urandom)); end
        join
        total++;
        if (order_q.size() != 4 || order_q[0] != 0 || order_q[1] != 1 || order_q[2] != 0 || order_q[3] != 1) begin
            bad++;
            $display("FAIL rr_order got_n=%0d got=%p want='{0,1,0,1}", order_q.size(), order_q);
        end
        total++;
        if (stab_err !== 0) begin bad++; $display("FAIL rr_operand_hold got=%0d want=0", stab_err); end
    endtask

    task automatic test_stall();
        int n;
        stall = 1'b1;
        a0 = 8'd2; b0 = 8'd3; req0 = 1'b1;
        n = 0;
        while (pipe_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (pipe_req === 1'b1 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n < TIMEOUT || n > TIMEOUT + 1) begin
            bad++;
            $display("FAIL stall_cycles got=%0d want=%0d..%0d", n, TIMEOUT, TIMEOUT + 1);
        end
        n = 0;
        while (ack0 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if ({timeout_err, pipe_req, ack0, prod} !== {1'b1, 1'b0, 1'b1, 16'd0}) begin
            bad++;
            $display("FAIL stall_state terr=%b preq=%b ack0=%b prod=%0d want 1/0/1/0", timeout_err, pipe_req, ack0, prod);
        end
        req0 = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        client_txn(1'b0, 8'd6, 8'd7);
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL stall_sticky got=%b want=1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int n;
        dly = 40;
        a1 = 8'd10; b1 = 8'd11; req1 = 1'b1;
        n = 0;
        while (pipe_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({pipe_req, ack1, ack0, prod, timeout_err} !== '0) begin
            bad++;
            $display("FAIL rstmid_clear preq=%b ack1=%b ack0=%b prod=%0d terr=%b want all 0", pipe_req, ack1, ack0, prod, timeout_err);
        end
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        order_q.delete();
        fork
            client_txn(1'b0, 8'd4, 8'd4);
            client_txn(1'b1, 8'd5, 8'd5);
        join
        total++;
        if (order_q.size() != 2 || order_q[0] != 0) begin
            bad++;
            $display("FAIL rstmid_first_grant got=%p want first 0", order_q);
        end
    endtask

    task automatic test_slow_ack();
        int n;
        dly = 40;
        a0 = 8'd12; b0 = 8'd13; req0 = 1'b1;
        n = 0;
        while (pipe_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (ack0 !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        total++;
        if (n < 2 * 4 + 2 || n > 2 * 4 + 6) begin
            bad++;
            $display("FAIL slow_latency got=%0d want=%0d..%0d", n, 2 * 4 + 2, 2 * 4 + 6);
        end
        total++;
        if ({prod, timeout_err} !== {16'd156, 1'b0}) begin
            bad++;
            $display("FAIL slow_result prod=%0d terr=%b want 156/0", prod, timeout_err);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int batch = 0; batch < 4; batch++) begin
            dly = int'($urandom_range(2, 45));
            fork
                begin
                    for (int k = 0; k < 5; k++) begin
                        repeat ($urandom_range(0, 5)) @(negedge clk);
                        client_txn(1'b0, W'($urandom), W'($urandom));
                    end
                end
                begin
                    for (int k = 0; k < 5; k++) begin
                        repeat ($urandom_range(0, 5)) @(negedge clk);
                        client_txn(1'b1, W'($urandom), W'($urandom));
                    end
                end
            join
        end
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL random_no_timeout got=%b want=0", timeout_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_slow_ack();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
